// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
//   Receive end of the LED PWM link. Measures the duty ratio (0..100 %) of a
//   PWM waveform whose nominal period is 100 clock-enable ticks, sampled on
//   the 10 kHz clock enable. One result is reported per measured period. A
//   flat line (0 % / 100 %) produces one result per timeout window.
//
// Parameters
//   PERIOD_TOL    accepted period deviation in CE ticks (100 +/- TOL), 0..20
//
// Ports
//   I_CLK_100MHZ  in   1  system clock, single clock domain
//   I_RST         in   1  synchronous, active-high reset
//   I_CE_10KHZ    in   1  clock enable, 1-cycle strobe
//   I_PULSE       in   1  PWM input, asynchronous to I_CLK_100MHZ
//   O_DUTY        out  7  last valid duty in %, holds between results
//   O_VALID       out  1  1-cycle strobe: new O_DUTY value
//   O_ERR         out  1  1-cycle strobe: period out of range or edge lost
//   O_LOCK        out  1  high while locked to a reference rising edge

module pwm_duty_decoder #(
  parameter int unsigned PERIOD_TOL = 2
) (
  input  logic       I_CLK_100MHZ,
  input  logic       I_RST,
  input  logic       I_CE_10KHZ,
  input  logic       I_PULSE,
  output logic [6:0] O_DUTY,
  output logic       O_VALID,
  output logic       O_ERR,
  output logic       O_LOCK
);

  // Timeout window and accepted period range, in CE ticks.
  localparam logic [8:0] WIN     = 9'(100 + PERIOD_TOL + 1);
  localparam logic [7:0] PER_MIN = 8'(100 - PERIOD_TOL);
  localparam logic [7:0] PER_MAX = 8'(100 + PERIOD_TOL);

  typedef enum logic {
    ST_ACQ,
    ST_LOCK
  } state_t;

  state_t     state;

  logic       sync_meta;
  logic       sync_s;
  logic       r_smp;

  logic [7:0] cnt_per;
  logic [7:0] cnt_high;

  logic [6:0] duty_r;
  logic       valid_r;
  logic       err_r;
  logic       lock_r;

  logic       edge_det;
  logic       timeout;
  logic       per_in_range;
  logic [7:0] per_inc;
  logic [7:0] high_inc;
  logic [6:0] duty_clip;

  // Two-flop synchronizer, runs every clock regardless of the enable.
  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= I_PULSE;
      sync_s    <= sync_meta;
    end
  end

  always_comb begin
    edge_det     = sync_s & ~r_smp;
    per_inc      = (cnt_per == 8'hFF) ? cnt_per : cnt_per + 8'd1;
    high_inc     = (sync_s && (cnt_high != 8'hFF)) ? cnt_high + 8'd1 : cnt_high;
    // Compare in 9 bits so a saturated counter can never alias onto WIN.
    timeout      = ~edge_det && (({1'b0, cnt_per} + 9'd1) == WIN);
    per_in_range = (cnt_per >= PER_MIN) && (cnt_per <= PER_MAX);
    duty_clip    = (cnt_high > 8'd100) ? 7'd100 : cnt_high[6:0];
  end

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      state    <= ST_ACQ;
      r_smp    <= 1'b0;
      cnt_per  <= '0;
      cnt_high <= '0;
      duty_r   <= '0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      lock_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;

      if (I_CE_10KHZ) begin
        r_smp <= sync_s;

        // The edge tick is the first tick of the new period.
        if (edge_det) begin
          cnt_per  <= 8'd1;
          cnt_high <= 8'd1;
        end else if (timeout) begin
          cnt_per  <= '0;
          cnt_high <= '0;
        end else begin
          cnt_per  <= per_inc;
          cnt_high <= high_inc;
        end

        unique case (state)
          ST_ACQ: begin
            if (edge_det) begin
              state  <= ST_LOCK;
              lock_r <= 1'b1;
            end else if (timeout) begin
              // Flat line: report 0 % or 100 %; a mixed window without a
              // rising edge produces no result.
              if (cnt_high == 8'd0) begin
                duty_r  <= 7'd0;
                valid_r <= 1'b1;
              end else if (cnt_high == cnt_per) begin
                duty_r  <= 7'd100;
                valid_r <= 1'b1;
              end
            end
          end

          ST_LOCK: begin
            if (edge_det) begin
              // cnt_per still holds the length of the period just finished.
              if (per_in_range) begin
                duty_r  <= duty_clip;
                valid_r <= 1'b1;
              end else begin
                err_r <= 1'b1;
              end
            end else if (timeout) begin
              err_r  <= 1'b1;
              state  <= ST_ACQ;
              lock_r <= 1'b0;
            end
          end

          default: begin
            state  <= ST_ACQ;
            lock_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_DUTY  = duty_r;
  assign O_VALID = valid_r;
  assign O_ERR   = err_r;
  assign O_LOCK  = lock_r;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder
//   Drives pwm_duty_decoder with flat lines, directed boundary periods and
//   randomized PWM periods. Each clock-enable tick is compared against a
//   window/sum reference model of the decoder.

module tb_pwm_duty_decoder;

  localparam int TOL = 2;
  localparam int WIN = 100 + TOL + 1;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       pulse;
  logic [6:0] duty;
  logic       valid;
  logic       err;
  logic       lock;

  int checks   = 0;
  int failures = 0;

  // Reference model state: levels seen in the current measurement window.
  logic win_q[$];
  logic m_lock;
  logic m_prev;
  int   m_duty;

  pwm_duty_decoder #(
    .PERIOD_TOL(TOL)
  ) dut (
    .I_CLK_100MHZ(clk),
    .I_RST       (rst),
    .I_CE_10KHZ  (ce),
    .I_PULSE     (pulse),
    .O_DUTY      (duty),
    .O_VALID     (valid),
    .O_ERR       (err),
    .O_LOCK      (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    m_lock = 1'b0;
    m_prev = 1'b0;
    m_duty = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk); #1;
    check_val("rst_duty",  int'(duty),  0);
    check_val("rst_valid", int'(valid), 0);
    check_val("rst_err",   int'(err),   0);
    check_val("rst_lock",  int'(lock),  0);
    rst = 1'b0;
    model_reset();
  endtask

  // One CE tick carrying level lvl. The level is applied three clocks
  // ahead of the enable so it has crossed the synchronizer when sampled.
  task automatic tick(input logic lvl);
    int  n;
    int  h;
    int  exp_v;
    int  exp_e;
    pulse = lvl;
    @(posedge clk); #1;
    check_val("strobe_drop_valid", int'(valid), 0);
    check_val("strobe_drop_err",   int'(err),   0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;

    n = win_q.size();
    h = 0;
    foreach (win_q[i]) h += int'(win_q[i]);
    exp_v = 0;
    exp_e = 0;
    if (lvl && !m_prev) begin
      if (!m_lock) begin
        m_lock = 1'b1;
      end else if (n >= 100 - TOL && n <= 100 + TOL) begin
        exp_v  = 1;
        m_duty = (h > 100) ? 100 : h;
      end else begin
        exp_e = 1;
      end
      win_q.delete();
      win_q.push_back(lvl);
    end else if (n + 1 == WIN) begin
      if (!m_lock) begin
        if (h == 0) begin
          exp_v  = 1;
          m_duty = 0;
        end else if (h == n) begin
          exp_v  = 1;
          m_duty = 100;
        end
      end else begin
        exp_e  = 1;
        m_lock = 1'b0;
      end
      win_q.delete();
    end else begin
      win_q.push_back(lvl);
    end
    m_prev = lvl;

    check_val("valid", int'(valid), exp_v);
    check_val("err",   int'(err),   exp_e);
    check_val("lock",  int'(lock),  int'(m_lock));
    check_val("duty",  int'(duty),  m_duty);
  endtask

  task automatic flat(input logic lvl, input int ticks);
    for (int i = 0; i < ticks; i++) tick(lvl);
  endtask

  task automatic period(input int len, input int high);
    for (int i = 0; i < len; i++) tick(i < high);
  endtask

  int len;
  int high;
  int sel;

  initial begin
    rst   = 1'b1;
    ce    = 1'b0;
    pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Flat lines from reset.
    flat(1'b0, 215);
    flat(1'b1, 320);
    // Falling away from high with no new rising edge: mixed window.
    flat(1'b0, 220);

    // 50 % lock, then line forced low.
    for (int i = 0; i < 4; i++) period(100, 50);
    flat(1'b0, 230);

    // Extreme duties and a change between them.
    for (int i = 0; i < 3; i++) period(100, 1);
    for (int i = 0; i < 3; i++) period(100, 99);

    // Boundary periods.
    period(100, 30);
    period(100, 30);
    for (int i = 0; i < 2; i++) period(90, 20);
    period(102, 40);
    period(98, 60);
    period(97, 60);
    period(103, 50);
    period(100, 45);
    period(100, 45);

    // Reset mid-period while locked.
    period(100, 70);
    for (int i = 0; i < 40; i++) tick(1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) period(100, 35);

    // Randomized periods.
    for (int p = 0; p < 35; p++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       len = 100;
        1:       len = int'($urandom_range(98, 102));
        2:       len = int'($urandom_range(85, 110));
        default: begin
          case ($urandom_range(0, 3))
            0:       len = 97;
            1:       len = 98;
            2:       len = 102;
            default: len = 103;
          endcase
        end
      endcase
      high = int'($urandom_range(1, len - 1));
      period(len, high);
      if ($urandom_range(0, 15) == 0) do_reset();
    end
    flat(1'b0, 110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
